// File: rtl/loadip_pkg.sv
// Shared types and constants for the load-input ping-pong buffer read side.
package loadip_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLAIM      = 3'd1,
    STREAM     = 3'd2,
    RELEASE    = 3'd3,
    DRAIN_WAIT = 3'd4
  } loadip_state_t;

  localparam int LOADIP_RD_LATENCY = 1;
  localparam int LOADIP_QDEPTH     = 2;

  // True when a new strobe still fits: words held after this cycle's pop plus
  // words already requested from the buffer must leave room for one more.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       pop,
                                     input logic [1:0] inflight);
    logic [2:0] sum;
    sum = {1'b0, occ} + {1'b0, inflight} - {2'b00, pop};
    return sum < 3'(LOADIP_QDEPTH);
  endfunction

endpackage

// File: rtl/loadip_stream_reader_if.sv
// Valid/ready word stream from the load-input reader to the compute core.
interface loadip_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  // A beat transfers on a clock edge where tvalid and tready are both 1.
  // While tvalid=1 and tready=0 the source holds tdata/tlast stable, and it
  // never withdraws tvalid before the beat transfers.
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/loadip_skid_queue.sv
// Two-entry FIFO holding {last, data} words between the buffer read port and the stream.
module loadip_skid_queue
  import loadip_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [LOADIP_QDEPTH];
  logic         r_head;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;
  logic         w_wr_ptr;

  assign o_full    = (r_count == 2'(LOADIP_QDEPTH));
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_head];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Tail slot sits one past the head when a word is already held.
  assign w_wr_ptr  = r_head ^ r_count[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LOADIP_QDEPTH; k++) r_mem[k] <= '0;
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) r_mem[w_wr_ptr] <= i_wdata;
      if (w_do_pop) r_head <= ~r_head;
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

endmodule

// File: rtl/loadip_stream_reader.sv
// Claims a filled half of the load-input buffer and replays it as a valid/ready stream.
// Optional LOADIP_RD_STATS_EN adds frame and stall counters.
module loadip_stream_reader
  import loadip_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_ready,
  output logic                  o_rd_activate,
  input  logic [CNT_WIDTH-1:0]  i_rd_cnt,
  output logic                  o_rstrobe,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  loadip_stream_reader_if.master stream,
  output logic                  o_busy,
  output loadip_state_t         o_dbg_state
`ifdef LOADIP_RD_STATS_EN
  ,
  output logic [31:0]           o_frame_cnt,
  output logic [31:0]           o_stall_cnt
`endif
);

  localparam int QW = DATA_WIDTH + 1;

  loadip_state_t                r_state;
  logic [CNT_WIDTH-1:0]         r_remaining;
  logic [LOADIP_RD_LATENCY-1:0] r_pend;
  logic [LOADIP_RD_LATENCY-1:0] r_pend_last;
  logic                         r_rd_activate;
  logic                         r_busy;

  logic           w_strobe;
  logic           w_strobe_last;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic           w_done;
  logic [1:0]     w_count;
  logic [1:0]     w_inflight;
  logic [QW-1:0]  w_q_rdata;

  assign w_inflight    = 2'($countones(r_pend));
  assign w_pop         = !w_empty && stream.tready;
  assign w_strobe      = (r_state == STREAM) && (r_remaining != '0)
                         && credit_ok(w_count, w_pop, w_inflight);
  assign w_strobe_last = w_strobe && (r_remaining == CNT_WIDTH'(1));
  assign w_push        = r_pend[LOADIP_RD_LATENCY-1];
  // Nothing left to fetch and the final beat is leaving (or already left).
  assign w_done        = (r_remaining == '0) && (w_inflight == 2'd0)
                         && (w_empty || ((w_count == 2'd1) && w_pop));

  loadip_skid_queue #(.W(QW)) u_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata ({r_pend_last[LOADIP_RD_LATENCY-1], i_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_q_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_pend        <= '0;
      r_pend_last   <= '0;
      r_rd_activate <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pend      <= LOADIP_RD_LATENCY'({r_pend, w_strobe});
      r_pend_last <= LOADIP_RD_LATENCY'({r_pend_last, w_strobe_last});
      if (w_strobe) r_remaining <= r_remaining - CNT_WIDTH'(1);
      case (r_state)
        IDLE: begin
          if (i_rd_ready) begin
            r_state       <= CLAIM;
            r_remaining   <= i_rd_cnt;
            r_rd_activate <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        CLAIM:      r_state <= (r_remaining == '0) ? RELEASE : STREAM;
        STREAM:     if (w_done) r_state <= RELEASE;
        RELEASE: begin
          r_state       <= DRAIN_WAIT;
          r_rd_activate <= 1'b0;
        end
        // Wait for the buffer to withdraw this half so it is never claimed twice.
        DRAIN_WAIT: begin
          if (!i_rd_ready) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_rd_activate <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_activate = r_rd_activate;
  assign o_rstrobe     = w_strobe;
  assign o_busy        = r_busy;
  assign o_dbg_state   = r_state;
  assign stream.tvalid = !w_empty;
  assign stream.tdata  = w_q_rdata[DATA_WIDTH-1:0];
  assign stream.tlast  = w_q_rdata[DATA_WIDTH];

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_push && w_full));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_pop && w_empty));

`ifdef LOADIP_RD_STATS_EN
  logic [31:0] r_frame_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && stream.tlast && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (!w_empty && !stream.tready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_loadip_stream_reader.sv
// Bench for loadip_stream_reader: behavioural buffer model, randomized data/back-pressure, scoreboard.
module tb_loadip_stream_reader;
  import loadip_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int W  = DW + 1;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rd_ready = 1'b0;
  logic          o_rd_activate;
  logic [CW-1:0] i_rd_cnt = '0;
  logic          o_rstrobe;
  logic [DW-1:0] i_rdata = '0;
  logic          o_busy;
  loadip_state_t o_dbg_state;
`ifdef LOADIP_RD_STATS_EN
  logic [31:0]   o_frame_cnt;
  logic [31:0]   o_stall_cnt;
`endif

  loadip_stream_reader_if #(.DATA_WIDTH(DW)) axis ();

  loadip_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rd_ready    (i_rd_ready),
    .o_rd_activate (o_rd_activate),
    .i_rd_cnt      (i_rd_cnt),
    .o_rstrobe     (o_rstrobe),
    .i_rdata       (i_rdata),
    .stream        (axis.master),
    .o_busy        (o_busy),
    .o_dbg_state   (o_dbg_state)
`ifdef LOADIP_RD_STATS_EN
    ,
    .o_frame_cnt   (o_frame_cnt),
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  // ---------------- scoreboard / buffer model ----------------
  logic [W-1:0]  exp_q[$];
  int            buf_cnt_q[$];
  logic [DW-1:0] buf_word_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int mode = 0;
  int stall_seen, tog;
  int n_strobe, n_beat, act_cycles, dw_entries, max_out;
  int first_valid_cyc, claim_cyc, last_beat_cyc, act_fall_cyc;
  int last_pos[$];
  int cur_taken = 0;
  logic prev_act = 1'b0;
  loadip_state_t prev_state = IDLE;
  bit cooldown = 1'b0;
  bit pend_data = 1'b0;
  logic [DW-1:0] pend_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    n_strobe = 0; n_beat = 0; act_cycles = 0; dw_entries = 0; max_out = 0;
    first_valid_cyc = -1; claim_cyc = -1; last_beat_cyc = -1; act_fall_cyc = -1;
    stall_seen = 0; tog = 1;
    last_pos.delete();
  endtask

  task automatic offer(input int cnt);
    logic [DW-1:0] w;
    buf_cnt_q.push_back(cnt);
    for (int i = 0; i < cnt; i++) begin
      w = DW'($urandom_range(0, 255));
      buf_word_q.push_back(w);
      exp_q.push_back({1'(i == cnt - 1), w});
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [W-1:0] e;
    int out;
    @(posedge i_clk);
    #1;
    if (pend_data) begin
      i_rdata = pend_word;
      pend_data = 1'b0;
    end
    i_rd_ready = (buf_cnt_q.size() > 0) && !cooldown;
    i_rd_cnt   = (buf_cnt_q.size() > 0) ? CW'(buf_cnt_q[0]) : '0;
    cooldown   = 1'b0;
    case (mode)
      0: axis.tready = 1'b1;
      1: begin axis.tready = tog[0]; tog = tog ^ 1; end
      2: axis.tready = 1'($urandom_range(0, 1));
      default: axis.tready = (stall_seen >= 3);
    endcase
    #1;
    cyc++;
    if (o_dbg_state == CLAIM && claim_cyc < 0) claim_cyc = cyc;
    if (o_dbg_state == DRAIN_WAIT && prev_state != DRAIN_WAIT) dw_entries++;
    prev_state = o_dbg_state;
    if (axis.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (axis.tvalid && !axis.tready) stall_seen++;
    if (o_rd_activate) act_cycles++;
    if (o_rstrobe) begin
      n_strobe++;
      if (buf_cnt_q.size() > 0 && cur_taken < buf_cnt_q[0]) pend_word = buf_word_q.pop_front();
      else pend_word = 8'hEE;
      cur_taken++;
      pend_data = 1'b1;
    end
    if (axis.tvalid && axis.tready) begin
      n_beat++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      check("tdata", 32'(axis.tdata), 32'(e[DW-1:0]));
      check("tlast", 32'(axis.tlast), 32'(e[DW]));
      if (axis.tlast) begin
        last_pos.push_back(n_beat);
        last_beat_cyc = cyc;
      end
    end
    out = n_strobe - n_beat;
    if (out > max_out) max_out = out;
    if (prev_act && !o_rd_activate) begin
      act_fall_cyc = cyc;
      check("strobes_per_half", cur_taken, (buf_cnt_q.size() > 0) ? buf_cnt_q[0] : -1);
      if (buf_cnt_q.size() > 0) begin
        for (int k = cur_taken; k < buf_cnt_q[0]; k++) void'(buf_word_q.pop_front());
        void'(buf_cnt_q.pop_front());
      end
      cur_taken = 0;
      cooldown = 1'b1;
    end
    prev_act = o_rd_activate;
  endtask

  task automatic run_done(input int budget);
    int k = 0;
    while (!(buf_cnt_q.size() == 0 && exp_q.size() == 0 && o_dbg_state == IDLE) && k < budget) begin
      step();
      k++;
    end
    check("done_in_budget", 32'(k < budget), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(axis.tvalid), 0);
    check({tag, "_tdata"}, 32'(axis.tdata), 0);
    check({tag, "_tlast"}, 32'(axis.tlast), 0);
    check({tag, "_rstrobe"}, 32'(o_rstrobe), 0);
    check({tag, "_activate"}, 32'(o_rd_activate), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int total, k;
`ifdef LOADIP_RD_STATS_EN
    logic [31:0] frame0, stall0;
`endif
    axis.tready = 1'b1;
    clear_obs();
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    check("reset_state", 32'(o_dbg_state), 32'(IDLE));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Count 4, full throughput
    clear_obs(); mode = 0; offer(4); run_done(60);
    check("t1_strobes", n_strobe, 4);
    check("t1_beats", n_beat, 4);
    check("t1_first_valid_latency", first_valid_cyc - claim_cyc, 3);
    check("t1_consecutive", last_beat_cyc - first_valid_cyc, 3);
    check("t1_nlast", last_pos.size(), 1);
    if (last_pos.size() > 0) check("t1_last_pos", last_pos[0], 4);
    check("t1_release_timing", act_fall_cyc - last_beat_cyc, 2);

    // Count 6, ready toggling 1010...
    clear_obs(); mode = 1; offer(6); run_done(80);
    check("t2_beats", n_beat, 6);
    check("t2_outstanding_le2", 32'(max_out <= 2), 1);
    if (last_pos.size() > 0) check("t2_last_pos", last_pos[0], 6);

    // Count 0
    clear_obs(); mode = 0; offer(0); run_done(30);
    check("t3_activate_cycles", act_cycles, 2);
    check("t3_strobes", n_strobe, 0);
    check("t3_beats", n_beat, 0);
    check("t3_idle", 32'(o_dbg_state), 32'(IDLE));

    // Back-to-back halves 3 then 5
    clear_obs(); mode = 0; offer(3); offer(5); run_done(120);
    check("t4_beats", n_beat, 8);
    check("t4_nlast", last_pos.size(), 2);
    if (last_pos.size() == 2) begin
      check("t4_last_a", last_pos[0], 3);
      check("t4_last_b", last_pos[1], 8);
    end
    check("t4_drain_entries", dw_entries, 2);

    // Reset during beat 2 of 5
    clear_obs(); mode = 0; offer(5);
    k = 0;
    while (n_beat < 2 && k < 40) begin step(); k++; end
    check("t5_reached_beat2", n_beat, 2);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_midreset");
    exp_q.delete(); buf_cnt_q.delete(); buf_word_q.delete();
    pend_data = 1'b0; cur_taken = 0; prev_act = 1'b0; cooldown = 1'b0; prev_state = IDLE;
    i_rd_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check("t5_state_after_reset", 32'(o_dbg_state), 32'(IDLE));
    clear_obs(); offer(4); run_done(60);
    check("t5_beats_after", n_beat, 4);
    if (last_pos.size() > 0) check("t5_last_pos", last_pos[0], 4);

    // Stall counting: ready low for first 3 valid cycles
`ifdef LOADIP_RD_STATS_EN
    frame0 = o_frame_cnt; stall0 = o_stall_cnt;
`endif
    clear_obs(); mode = 3; offer(4); run_done(60);
    check("t6_beats", n_beat, 4);
`ifdef LOADIP_RD_STATS_EN
    check("t6_stall_cnt", o_stall_cnt - stall0, 3);
    check("t6_frame_cnt", o_frame_cnt - frame0, 1);
`endif

    // Randomized halves with random back-pressure
    for (int r = 0; r < 8; r++) begin
      clear_obs(); mode = 2;
      total = $urandom_range(0, 9);
      offer(total);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 6);
        offer(k);
        total += k;
      end
      run_done(400);
      check("rnd_beats", n_beat, total);
      check("rnd_outstanding_le2", 32'(max_out <= 2), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
